// File: rtl/dl_wr_buffer_if.sv
// Byte-write strobe input and word-wide memory request bus of the download write buffer.
// The slave modport is the buffer side; the master modport is the download engine plus arbiter side.
interface dl_wr_buffer_if #(
  parameter int AW = 25
);
  logic          in_wr;
  logic [AW-1:0] in_a;
  logic [7:0]    in_d;
  logic          mem_req;
  logic [AW-2:0] mem_a;
  logic [15:0]   mem_d;
  logic [1:0]    mem_be;
  logic          mem_ack;

  modport slave (
    input  in_wr, in_a, in_d, mem_ack,
    output mem_req, mem_a, mem_d, mem_be
  );

  modport master (
    output in_wr, in_a, in_d, mem_ack,
    input  mem_req, mem_a, mem_d, mem_be
  );
endinterface

// File: rtl/dl_wr_buffer.sv
// Download write buffer: queues byte strobes and replays them to the SDRAM arbiter over req/ack.
// Define DL_WR_MERGE_EN to merge an even/odd byte pair at the FIFO head into one 16-bit access.
module dl_wr_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 25
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dl_wr_buffer_if.slave          bus,
  input  logic                   downloading,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   fifo_a_q [DEPTH];
  logic [AW-1:0]   fifo_a_d [DEPTH];
  logic [7:0]      fifo_d_q [DEPTH];
  logic [7:0]      fifo_d_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-2:0]   mem_a_q, mem_a_d;
  logic [15:0]     mem_d_q, mem_d_d;
  logic [1:0]      mem_be_q, mem_be_d;
  logic            merged_q, merged_d;
  logic            dl_q, dl_d;
  logic            pending_q, pending_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;

  logic            full_s, empty_s, accept_s, push_s, drop_s, merge_s;
  logic            rise_s, fall_s, pend_s;
  logic [1:0]      pop_n_s;
  logic [AW-1:0]   head_a_s;
  logic [7:0]      head_d_s;
`ifdef DL_WR_MERGE_EN
  logic [AW-1:0]   nxt_a_s;
  logic [7:0]      nxt_d_s;
`endif

  // Next-state logic for FIFO, request FSM, done tracking and overflow flag.
  always_comb begin
    full_s   = (count_q == CW'(DEPTH));
    empty_s  = (count_q == {CW{1'b0}});
    accept_s = mem_req_q && bus.mem_ack;
    pop_n_s  = accept_s ? (merged_q ? 2'd2 : 2'd1) : 2'd0;
    push_s   = bus.in_wr && (!full_s || accept_s);
    drop_s   = bus.in_wr && full_s && !accept_s;
    head_a_s = fifo_a_q[rd_ptr_q];
    head_d_s = fifo_d_q[rd_ptr_q];

`ifdef DL_WR_MERGE_EN
    nxt_a_s  = fifo_a_q[rd_ptr_q + PW'(1)];
    nxt_d_s  = fifo_d_q[rd_ptr_q + PW'(1)];
    merge_s  = (count_q >= CW'(2)) && !head_a_s[0] && (nxt_a_s == head_a_s + AW'(1));
`else
    merge_s  = 1'b0;
`endif

    fifo_a_d = fifo_a_q;
    fifo_d_d = fifo_d_q;
    if (push_s) begin
      fifo_a_d[wr_ptr_q] = bus.in_a;
      fifo_d_d[wr_ptr_q] = bus.in_d;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d           = wr_ptr_q;
    end
    rd_ptr_d = rd_ptr_q + PW'(pop_n_s);
    count_d  = count_q + CW'(push_s) - CW'(pop_n_s);

    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    mem_be_d  = mem_be_q;
    merged_d  = merged_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b1;
          mem_a_d   = head_a_s[AW-1:1];
          if (merge_s) begin
            merged_d = 1'b1;
            mem_be_d = 2'b11;
`ifdef DL_WR_MERGE_EN
            mem_d_d  = {nxt_d_s, head_d_s};
`else
            mem_d_d  = {head_d_s, head_d_s};
`endif
          end else begin
            merged_d = 1'b0;
            mem_be_d = head_a_s[0] ? 2'b10 : 2'b01;
            mem_d_d  = {head_d_s, head_d_s};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (accept_s) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d   = S_WAIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A download end is remembered until the buffer is drained and idle.
    dl_d   = downloading;
    rise_s = downloading && !dl_q;
    fall_s = !downloading && dl_q;
    pend_s = pending_q || fall_s;
    if (rise_s) begin
      pending_d = 1'b0;
      done_d    = 1'b0;
    end else if (pend_s && empty_s && (state_q == S_IDLE)) begin
      pending_d = 1'b0;
      done_d    = 1'b1;
    end else begin
      pending_d = pend_s;
      done_d    = 1'b0;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (rise_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers with synchronous active-low reset; FIFO storage is not reset.
  always_ff @(posedge clk) begin
    fifo_a_q <= fifo_a_d;
    fifo_d_q <= fifo_d_d;
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      mem_req_q  <= 1'b0;
      mem_a_q    <= {(AW-1){1'b0}};
      mem_d_q    <= 16'h0000;
      mem_be_q   <= 2'b00;
      merged_q   <= 1'b0;
      dl_q       <= 1'b0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      mem_be_q   <= mem_be_d;
      merged_q   <= merged_d;
      dl_q       <= dl_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.mem_req = mem_req_q;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_d   = mem_d_q;
  assign bus.mem_be  = mem_be_q;
  assign count       = count_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign busy        = downloading || !empty_s || (state_q == S_WAIT);
endmodule

// File: tb/tb_dl_wr_buffer.sv
// Directed self-checking bench for dl_wr_buffer; expectations follow DL_WR_MERGE_EN when defined.
module tb_dl_wr_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 25;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       downloading;
  logic [3:0] count;
  logic       busy, done, overflow;
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [AW-2:0] got_a  [32];
  logic [15:0]   got_d  [32];
  logic [1:0]    got_be [32];
  int            got_n;

  dl_wr_buffer_if #(.AW(AW)) bus ();

  dl_wr_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .downloading (downloading),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d);
    bus.in_wr = 1'b1;
    bus.in_a  = a;
    bus.in_d  = d;
    tick();
    bus.in_wr = 1'b0;
  endtask

  // Records every access offered while ack is held high, for a fixed cycle budget.
  task automatic collect(input int cycles);
    got_n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.mem_req && bus.mem_ack && got_n < 32) begin
        got_a[got_n]  = bus.mem_a;
        got_d[got_n]  = bus.mem_d;
        got_be[got_n] = bus.mem_be;
        got_n++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    downloading = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0h want 0", bus.mem_req); end
    n_checks++; if (bus.mem_a !== 24'h0) begin n_fail++; $display("FAIL reset_mem_a: got %0h want 0", bus.mem_a); end
    n_checks++; if (bus.mem_d !== 16'h0) begin n_fail++; $display("FAIL reset_mem_d: got %0h want 0", bus.mem_d); end
    n_checks++; if (bus.mem_be !== 2'b00) begin n_fail++; $display("FAIL reset_mem_be: got %0h want 0", bus.mem_be); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0h want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.mem_ack = 1'b1;
    strobe(25'h200000, 8'hA5);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count1: got %0d want 1", count); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %0h want 0", bus.mem_req); end
    tick();
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %0h want 1", bus.mem_req); end
    n_checks++; if (bus.mem_a !== 24'h100000) begin n_fail++; $display("FAIL single_mem_a: got %0h want 100000", bus.mem_a); end
    n_checks++; if (bus.mem_be !== 2'b01) begin n_fail++; $display("FAIL single_mem_be: got %0h want 1", bus.mem_be); end
    n_checks++; if (bus.mem_d !== 16'hA5A5) begin n_fail++; $display("FAIL single_mem_d: got %0h want a5a5", bus.mem_d); end
    tick();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %0h want 0", bus.mem_req); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL single_count0: got %0d want 0", count); end
    tick();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_idle: got %0h want 0", bus.mem_req); end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_overflow();
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 9; i++) strobe(25'h10 + 25'(3 * i), 8'h30 + 8'(i));
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0h want 1", overflow); end
    bus.mem_ack = 1'b1;
    collect(30);
    bus.mem_ack = 1'b0;
    n_checks++; if (got_n !== 8) begin n_fail++; $display("FAIL ovf_replay_n: got %0d want 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      ea = 25'h10 + 25'(3 * i);
      ed = 8'h30 + 8'(i);
      n_checks++;
      if (got_a[i] !== ea[AW-1:1] || got_be[i] !== (ea[0] ? 2'b10 : 2'b01) || got_d[i] !== {ed, ed}) begin
        n_fail++;
        $display("FAIL ovf_replay_%0d: got a=%0h be=%0h d=%0h want a=%0h be=%0h d=%0h", i, got_a[i], got_be[i],
                 got_d[i], ea[AW-1:1], (ea[0] ? 2'b10 : 2'b01), {ed, ed});
      end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0h want 1", overflow); end
    downloading = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_fall: got %0h want 1", overflow); end
    downloading = 1'b1;
    tick();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_rise: got %0h want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) strobe(25'h40 + 25'(2 * i), 8'h50 + 8'(i));
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fpp_full: got %0d want 8", count); end
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL fpp_req: got %0h want 1", bus.mem_req); end
    bus.mem_ack = 1'b1;
    strobe(25'h60, 8'h77);
    bus.mem_ack = 1'b0;
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fpp_count: got %0d want 8", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %0h want 0", overflow); end
    tick();
    bus.mem_ack = 1'b1;
    collect(40);
    bus.mem_ack = 1'b0;
    n_checks++; if (got_n !== 8) begin n_fail++; $display("FAIL fpp_drain_n: got %0d want 8", got_n); end
    n_checks++; if (got_a[7] !== 24'h30 || got_d[7] !== 16'h7777) begin n_fail++; $display("FAIL fpp_last: got a=%0h d=%0h want a=30 d=7777", got_a[7], got_d[7]); end
  endtask

  task automatic test_merge();
    bus.mem_ack = 1'b0;
    strobe(25'h000100, 8'h5A);
    strobe(25'h182000, 8'h11);
    strobe(25'h182001, 8'h22);
    bus.mem_ack = 1'b1;
    collect(20);
    bus.mem_ack = 1'b0;
    n_checks++; if (got_a[0] !== 24'h80 || got_d[0] !== 16'h5A5A) begin n_fail++; $display("FAIL merge_first: got a=%0h d=%0h want a=80 d=5a5a", got_a[0], got_d[0]); end
`ifdef DL_WR_MERGE_EN
    n_checks++; if (got_n !== 2) begin n_fail++; $display("FAIL merge_n: got %0d want 2", got_n); end
    n_checks++; if (got_a[1] !== 24'hC1000 || got_be[1] !== 2'b11 || got_d[1] !== 16'h2211) begin n_fail++; $display("FAIL merge_pair: got a=%0h be=%0h d=%0h want a=c1000 be=3 d=2211", got_a[1], got_be[1], got_d[1]); end
`else
    n_checks++; if (got_n !== 3) begin n_fail++; $display("FAIL merge_n: got %0d want 3", got_n); end
    n_checks++; if (got_a[1] !== 24'hC1000 || got_be[1] !== 2'b01 || got_d[1] !== 16'h1111) begin n_fail++; $display("FAIL merge_lo: got a=%0h be=%0h d=%0h want a=c1000 be=1 d=1111", got_a[1], got_be[1], got_d[1]); end
    n_checks++; if (got_a[2] !== 24'hC1000 || got_be[2] !== 2'b10 || got_d[2] !== 16'h2222) begin n_fail++; $display("FAIL merge_hi: got a=%0h be=%0h d=%0h want a=c1000 be=2 d=2222", got_a[2], got_be[2], got_d[2]); end
`endif
  endtask

  task automatic test_done();
    int last_req = -1;
    int done_at  = -1;
    int n_done   = 0;
    logic busy_last = 1'b0;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) strobe(25'h300 + 25'(2 * i), 8'h90 + 8'(i));
    downloading = 1'b0;
    tick(); tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL done_busy_pending: got %0h want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %0h want 0", done); end
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (bus.mem_req) begin last_req = k; busy_last = busy; end
      if (done) begin n_done++; done_at = k; end
      tick();
    end
    bus.mem_ack = 1'b0;
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL done_count: got %0d want 1", n_done); end
    n_checks++; if (done_at !== last_req + 2) begin n_fail++; $display("FAIL done_timing: got %0d want %0d", done_at, last_req + 2); end
    n_checks++; if (busy_last !== 1'b1) begin n_fail++; $display("FAIL done_busy_drain: got %0h want 1", busy_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy_end: got %0h want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    bus.mem_ack = 1'b0;
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) strobe(25'h400 + 25'(2 * i), 8'hC0 + 8'(i));
    downloading = 1'b0;
    tick();
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_wait: got %0h want 1", bus.mem_req); end
    reset_n = 1'b0;
    tick();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %0h want 0", bus.mem_req); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) n_done++;
    end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d want 0", n_done); end
  endtask

  initial begin
    bus.in_wr   = 1'b0;
    bus.in_a    = '0;
    bus.in_d    = 8'h00;
    bus.mem_ack = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_merge();
    test_done();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
